game_level_fsm: RTL
===================

// Module: game_level_fsm
// PURPOSE
//  Level/state controller driving the obstacle counter block: consumes game_time and
//  player collision, produces menuScreen/playerWon/playerLost/reset_obj_count for it.
//  Sequences MENU -> PLAY -> WON/LOST -> MENU; splits a level into timed phases and
//  pulses reset_obj_count at each phase boundary so obstacles restart for the next phase.
// PARAMETERS
//  WIN_TIME    1500  game_time value at which the level is won (fits 11 bits)
//  PHASE_TIME  300   game_time cycles per phase; boundaries at k*PHASE_TIME, k>=1
//  NUM_PHASES  5     phase count; level_phase saturates at NUM_PHASES-1
//  RESULT_HOLD 60    min cycles WON/LOST held before start may return to MENU
//  NUM_LIVES   3     initial lives (LIVES_EN only), 1..3
//  INVULN_TIME 30    post-hit cycles with collision ignored (LIVES_EN only)
// PORTS
//  clk             in   1   system clock
//  reset           in   1   synchronous, active-high reset
//  start_btn       in   1   start/continue button, level, already synchronised
//  collision       in   1   player overlaps an obstacle, level
//  game_time       in   11  level cycle count from obstacle counter (0 while not PLAY)
//  menuScreen      out  1   1 in MENU
//  playerWon       out  1   1 in WON
//  playerLost      out  1   1 in LOST
//  reset_obj_count out  1   one-cycle pulse: restart obstacle position counter
//  level_phase     out  3   current phase index, 0..NUM_PHASES-1
//  lives_left      out  2   remaining lives; constant 0 without LIVES_EN
// BEHAVIOUR
//  - Reset (sync, clk edge with reset=1): state=MENU, menuScreen=1, playerWon=0,
//    playerLost=0, reset_obj_count=0, level_phase=0, hold timer=0, lives_left=NUM_LIVES
//    (0 if LIVES_EN undefined), start edge register=0. Reset mid-game aborts to MENU.
//  - All outputs registered; flags decode the state register (no extra latency).
//  - start_rise = start_btn & ~start_q; holding the button yields one event only.
//  - MENU: start_rise -> PLAY next cycle; level_phase<=0, lives reload.
//  - PLAY: priority collision > win > phase boundary, evaluated each cycle:
//    collision -> LOST (LIVES_EN: see below);
//    game_time >= WIN_TIME -> WON;
//    game_time == (level_phase+1)*PHASE_TIME and level_phase < NUM_PHASES-1 ->
//    level_phase+1 and reset_obj_count=1 for exactly that one following cycle.
//    Boundary compare uses a registered next_boundary (add PHASE_TIME), no multiplier.
//  - WON/LOST: hold timer counts from 0; start_rise ignored until timer >= RESULT_HOLD-1,
//    then start_rise -> MENU. Timer saturates, never wraps.
//  - collision/start_btn ignored outside states stated above; game_time not used outside PLAY.
//  - reset_obj_count never asserted outside PLAY (counter already clears on flags).
// CONFIGURATION
//  LIVES_EN defined: collision in PLAY with lives_left>1 -> lives_left-1, reset_obj_count
//   pulse, INVULN_TIME cycles in which collision ignored (still PLAY, game_time runs);
//   collision with lives_left==1 -> LOST. Win check still active during invuln.
//  LIVES_EN undefined: first collision -> LOST; lives_left tied 0; no invuln logic.
// STRUCTURE
//  - game_pkg: typedef enum logic[1:0] game_state_t {MENU,PLAY,WON,LOST};
//    GAME_TIME_W=11, PHASE_W=3, LIVES_W=2 localparams.
//  - Sub-module rise_detect (clk, reset, d -> pulse) for start_btn edge.
//  - Main FSM, phase counter/next_boundary, hold timer, lives/invuln in this file.
// TESTING
//  1 reset held 3 cycles mid-PLAY -> next cycle menuScreen=1, level_phase=0, others 0.
//  2 start_btn held 10 cycles in MENU -> single MENU->PLAY; no re-entry after WON.
//  3 PLAY, game_time ramps 0..1500 -> reset_obj_count pulses at 300,600,900,1200 (1 cyc
//    each), level_phase 0->4, playerWon=1 cycle after game_time=1500.
//  4 collision and game_time=1500 same cycle -> playerLost=1, playerWon=0.
//  5 LOST, start_rise at hold cycle 10 -> ignored; at cycle 60 -> MENU next cycle.
//  6 LIVES_EN: 3 collisions spaced >30 cycles -> lives 3->2->1 with pulses, 3rd ->
//    LOST; collision 10 cycles after hit -> ignored.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and widths for the game level controller
package game_pkg;

  typedef enum logic [1:0] {
    MENU = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } game_state_t;

  localparam int GAME_TIME_W = 11;
  localparam int PHASE_W     = 3;
  localparam int LIVES_W     = 2;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - single-cycle pulse on a rising edge of a synchronised level
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic d_q;

  // remember last cycle's level so a held input produces one event only
  always_ff @(posedge clk) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/game_level_fsm.sv
// rtl/game_level_fsm.sv - MENU/PLAY/WON/LOST sequencer with timed phases; optional LIVES_EN
module game_level_fsm
  import game_pkg::*;
#(
  parameter int WIN_TIME    = 1500,
  parameter int PHASE_TIME  = 300,
  parameter int NUM_PHASES  = 5,
  parameter int RESULT_HOLD = 60
`ifdef LIVES_EN
  ,
  parameter int NUM_LIVES   = 3,
  parameter int INVULN_TIME = 30
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_btn,
  input  logic                   collision,
  input  logic [GAME_TIME_W-1:0] game_time,
  output logic                   menuScreen,
  output logic                   playerWon,
  output logic                   playerLost,
  output logic                   reset_obj_count,
  output logic [PHASE_W-1:0]     level_phase,
  output logic [LIVES_W-1:0]     lives_left
);

  localparam int HOLD_W = 8;
  localparam logic [GAME_TIME_W-1:0] WIN_T      = GAME_TIME_W'(WIN_TIME);
  localparam logic [GAME_TIME_W-1:0] PHASE_T    = GAME_TIME_W'(PHASE_TIME);
  localparam logic [PHASE_W-1:0]     LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
  localparam logic [HOLD_W-1:0]      HOLD_LAST  = HOLD_W'(RESULT_HOLD - 1);

  game_state_t              state, state_d;
  logic [PHASE_W-1:0]       phase_d;
  logic [GAME_TIME_W-1:0]   next_boundary, boundary_d;
  logic [HOLD_W-1:0]        hold, hold_d;
  logic                     pulse_q, pulse_d;
  logic                     start_rise;
  logic                     hit;

`ifdef LIVES_EN
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NUM_LIVES);
  localparam logic [7:0]         INV_T      = 8'(INVULN_TIME);
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [7:0]         inv_q, inv_d;
`endif

  rise_detect u_start_rise (
    .clk   (clk),
    .reset (reset),
    .d     (start_btn),
    .pulse (start_rise)
  );

  // register state, phase bookkeeping, result hold timer and optional lives
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= MENU;
      level_phase   <= '0;
      next_boundary <= PHASE_T;
      hold          <= '0;
      pulse_q       <= 1'b0;
`ifdef LIVES_EN
      lives_q       <= LIVES_INIT;
      inv_q         <= '0;
`endif
    end else begin
      state         <= state_d;
      level_phase   <= phase_d;
      next_boundary <= boundary_d;
      hold          <= hold_d;
      pulse_q       <= pulse_d;
`ifdef LIVES_EN
      lives_q       <= lives_d;
      inv_q         <= inv_d;
`endif
    end
  end

  // next-state: collision beats win beats phase boundary while playing
  always_comb begin
    state_d    = state;
    phase_d    = level_phase;
    boundary_d = next_boundary;
    hold_d     = hold;
    pulse_d    = 1'b0;
    hit        = 1'b0;
`ifdef LIVES_EN
    lives_d    = lives_q;
    inv_d      = inv_q;
`endif
    case (state)
      MENU: begin
        if (start_rise) begin
          state_d    = PLAY;
          phase_d    = '0;
          boundary_d = PHASE_T;
`ifdef LIVES_EN
          lives_d    = LIVES_INIT;
          inv_d      = '0;
`endif
        end
      end
      PLAY: begin
`ifdef LIVES_EN
        if (inv_q != '0) inv_d = inv_q - 8'd1;
        hit = collision && (inv_q == '0);
`else
        hit = collision;
`endif
        if (hit) begin
`ifdef LIVES_EN
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            pulse_d = 1'b1;
            inv_d   = INV_T;
          end else begin
            state_d = LOST;
            hold_d  = '0;
          end
`else
          state_d = LOST;
          hold_d  = '0;
`endif
        end else if (game_time >= WIN_T) begin
          state_d = WON;
          hold_d  = '0;
        end else if ((game_time == next_boundary) && (level_phase < LAST_PHASE)) begin
          phase_d    = level_phase + 3'd1;
          boundary_d = next_boundary + PHASE_T;
          pulse_d    = 1'b1;
        end
      end
      default: begin
        if (start_rise && (hold >= HOLD_LAST)) state_d = MENU;
        else if (hold != '1)                   hold_d  = hold + 8'd1;
      end
    endcase
  end

  assign menuScreen      = (state == MENU);
  assign playerWon       = (state == WON);
  assign playerLost      = (state == LOST);
  assign reset_obj_count = pulse_q;
`ifdef LIVES_EN
  assign lives_left      = lives_q;
`else
  assign lives_left      = '0;
`endif

endmodule
